// File: rtl/labelled_reg_arbiter.sv
// Arbitrates L/H writers onto one label-tagged register; every H->L downgrade is preceded by a
// zero-scrub so H data never becomes visible under label L.
module labelled_reg_arbiter #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned SCRUB_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_l,
  input  logic [WIDTH-1:0] data_l,
  output logic             gnt_l,
  input  logic             req_h,
  input  logic [WIDTH-1:0] data_h,
  output logic             gnt_h,
  output logic             reg_wen,
  output logic             reg_lbl,
  output logic [WIDTH-1:0] reg_wdata,
  output logic             cur_lbl,
  output logic             busy
);

  localparam int unsigned CntW = (SCRUB_CYCLES > 1) ? $clog2(SCRUB_CYCLES + 1) : 1;

  typedef enum logic [0:0] {StIdle, StScrub} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             last_q, last_d;       // 1: H granted last
  logic             cur_lbl_q, cur_lbl_d;
  logic             wen_q, wen_d;
  logic             lbl_q, lbl_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             gnt_l_q, gnt_l_d;
  logic             gnt_h_q, gnt_h_d;
  logic             busy_q, busy_d;
  logic             pick_l, pick_h;

  assign pick_l = req_l & (~req_h | last_q);
  assign pick_h = req_h & (~req_l | ~last_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    cur_lbl_d = cur_lbl_q;
    wen_d     = 1'b0;
    lbl_d     = lbl_q;
    wdata_d   = wdata_q;
    gnt_l_d   = 1'b0;
    gnt_h_d   = 1'b0;
    busy_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (pick_h) begin
          gnt_h_d   = 1'b1;
          wen_d     = 1'b1;
          lbl_d     = 1'b1;
          wdata_d   = data_h;
          cur_lbl_d = 1'b1;
          last_d    = 1'b1;
        end else if (pick_l && !cur_lbl_q) begin
          gnt_l_d = 1'b1;
          wen_d   = 1'b1;
          lbl_d   = 1'b0;
          wdata_d = data_l;
          last_d  = 1'b0;
        end else if (pick_l) begin
          // First scrub write issues here; cnt counts the writes still to follow.
          busy_d    = 1'b1;
          wen_d     = 1'b1;
          wdata_d   = '0;
          lbl_d     = (SCRUB_CYCLES > 1);
          cur_lbl_d = (SCRUB_CYCLES > 1);
          cnt_d     = CntW'(SCRUB_CYCLES - 1);
          state_d   = (SCRUB_CYCLES > 1) ? StScrub : StIdle;
        end
      end
      StScrub: begin
        busy_d    = 1'b1;
        wen_d     = 1'b1;
        wdata_d   = '0;
        lbl_d     = (cnt_q != CntW'(1));
        cur_lbl_d = (cnt_q != CntW'(1));
        cnt_d     = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      last_q    <= 1'b1;
      cur_lbl_q <= 1'b0;
      wen_q     <= 1'b0;
      lbl_q     <= 1'b0;
      wdata_q   <= '0;
      gnt_l_q   <= 1'b0;
      gnt_h_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      last_q    <= last_d;
      cur_lbl_q <= cur_lbl_d;
      wen_q     <= wen_d;
      lbl_q     <= lbl_d;
      wdata_q   <= wdata_d;
      gnt_l_q   <= gnt_l_d;
      gnt_h_q   <= gnt_h_d;
      busy_q    <= busy_d;
    end
  end

  assign gnt_l     = gnt_l_q;
  assign gnt_h     = gnt_h_q;
  assign reg_wen   = wen_q;
  assign reg_lbl   = lbl_q;
  assign reg_wdata = wdata_q;
  assign cur_lbl   = cur_lbl_q;
  assign busy      = busy_q;

endmodule
